// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids
// and bus widths.
package arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arbState_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way chooser: a valid lock wins a contested cycle,
// otherwise the round-robin pointer decides.
module rr_pick (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       win,
  output logic       any
);

  always_comb begin
    any = |req;
    win = rr;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = lock_valid ? lock_owner : rr;
      default: win = rr;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core and the loader, one access per two
// cycles, with round-robin fairness and a bounded lock burst.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic              lock_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Adr,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);

  localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

  arbState_t  state, stateNext;
  logic       owner;
  logic       rr;
  logic       lockActive;
  logic       lockOwner;
  logic [3:0] burstCnt;
  logic [4:0] burstInc;
  logic [1:0] reqVec;
  logic       lockValid;
  logic       lockReq;
  logic       keepLock;
  logic       win;
  logic       anyReq;

  assign rdata     = ReadData;
  assign reqVec    = {req_1, req_0};
  // A lock whose owner has stopped requesting no longer steers selection.
  assign lockValid = lockActive && reqVec[lockOwner];
  assign lockReq   = (owner == PORT_LDR) ? lock_1 : lock_0;
  assign burstInc  = {1'b0, burstCnt} + 5'd1;
  assign keepLock  = lockReq && (burstInc < BURST_LIM);

  rr_pick picker (
    .req       (reqVec),
    .rr        (rr),
    .lock_valid(lockValid),
    .lock_owner(lockOwner),
    .win       (win),
    .any       (anyReq)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      rvalid_0   <= 1'b0;
      rvalid_1   <= 1'b0;
      MemWrite   <= 1'b0;
      Adr        <= '0;
      WriteData  <= '0;
      owner      <= PORT_CORE;
      rr         <= PORT_CORE;
      lockActive <= 1'b0;
      lockOwner  <= PORT_CORE;
      burstCnt   <= '0;
    end else begin
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (lockActive && !reqVec[lockOwner]) begin
            lockActive <= 1'b0;
            burstCnt   <= '0;
          end
          if (anyReq) begin
            owner     <= win;
            Adr       <= (win == PORT_LDR) ? addr_1  : addr_0;
            WriteData <= (win == PORT_LDR) ? wdata_1 : wdata_0;
            MemWrite  <= (win == PORT_LDR) ? we_1    : we_0;
            gnt_0     <= (win == PORT_CORE);
            gnt_1     <= (win == PORT_LDR);
          end
        end
        ISSUE: begin
          // MemWrite still carries the current access type here.
          if (!MemWrite) begin
            rvalid_0 <= (owner == PORT_CORE);
            rvalid_1 <= (owner == PORT_LDR);
          end
          rr <= ~owner;
          if (keepLock) begin
            lockActive <= 1'b1;
            lockOwner  <= owner;
            burstCnt   <= burstInc[3:0];
          end else begin
            lockActive <= 1'b0;
            burstCnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the processor's single unified memory port (Adr / WriteData / MemWrite / ReadData) between the multicycle core and an external loader/debug master. It sits between `top`'s datapath memory interface and the memory model. It sequences one memory access at a time, alternates fairly between requesters, and lets a requester lock ownership for a bounded burst.

## Interface
Parameters:
- `BURST_MAX`, 4: maximum consecutive grants to one locked owner before it must yield (range 1..15).

Ports (index p = 0 core, p = 1 loader; each requester signal exists per port):
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge, reset when 0.
- `req_p` input 1: access request; held high with fields stable until `gnt_p`.
- `we_p` input 1: 1 = write, 0 = read.
- `lock_p` input 1: keep ownership after this access.
- `addr_p` input 32: byte address.
- `wdata_p` input 32: write data.
- `gnt_p` output 1: one-cycle pulse; this port's access is on the memory bus this cycle.
- `rvalid_p` output 1: one-cycle pulse; `rdata` holds this port's read data.
- `rdata` output 32: shared read data, equal to `ReadData`.
- `Adr` output 32: memory address.
- `WriteData` output 32: memory write data.
- `MemWrite` output 1: memory write strobe.
- `ReadData` input 32: memory read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE, no request: stay in IDLE. `MemWrite` = 0; `Adr` and `WriteData` hold their last values.
- IDLE, any `req_p` high: choose the winner and register `Adr`/`WriteData`/`MemWrite`(= `we`) from its fields. Set `owner` and go to ISSUE.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting, no active lock: the port named by round-robin pointer `rr` wins.
  - Active lock held by owner X, and X requests: X wins.
  - Active lock held by X, and X does not request: the lock is released and normal selection applies.
- ISSUE: `gnt_owner` = 1 for exactly one cycle and the memory bus carries the access. Always return to IDLE next cycle.
- On leaving ISSUE:
  - Read access: `rvalid_owner` = 1 in the following cycle.
  - `rr` is set to the other port.
  - If `lock_owner` was high during ISSUE and `burst_cnt+1 < BURST_MAX`: lock stays active and `burst_cnt` increments.
  - Otherwise: lock clears and `burst_cnt` = 0.
- A lock that reaches `BURST_MAX` forces one grant to the other port if that port is requesting.
- `rvalid` for the previous read and a new ISSUE may overlap; they are independent.
- Write accesses never produce `rvalid`.
- `lock` is ignored on the cycle it is raised together with `req`, until the first grant. Lock only takes effect from ISSUE onward.

## Timing
- Reset values: state IDLE; `gnt_0`, `gnt_1`, `rvalid_0`, `rvalid_1`, `MemWrite` = 0; `Adr`, `WriteData` = 0; `rr` = 0 (core first); lock inactive; `burst_cnt` = 0.
- Latency, request sampled at edge t (state IDLE):
  - cycle t+1: ISSUE, `gnt` and bus outputs valid.
  - cycle t+2: `rvalid` (reads).
- Throughput: one access per 2 cycles. The requester updates or drops its request in the cycle after `gnt`. The arbiter samples again on that cycle's closing edge.
- Reset asserted mid-ISSUE: the access is aborted at that edge. `MemWrite` is cleared the next cycle and no `rvalid` is issued.
- `rdata` is combinational passthrough of `ReadData`. Every other output is registered.

## Structure
- Package `arb_pkg`:
  - state encoding (IDLE = 0, ISSUE = 1);
  - port ids `PORT_CORE` = 0, `PORT_LDR` = 1;
  - width constants `ADDR_W` = 32, `DATA_W` = 32.
- Sub-module `rr_pick`: combinational 2-way chooser. Inputs are `req[1:0]`, `rr`, `lock_valid`, `lock_owner`; outputs are `win` and `any`.
- Top-level `mem_arbiter` holds the FSM, the bus registers, `rr`, the lock flag and `burst_cnt`.

## Test plan
- Reset held low 3 cycles with both `req` high: all outputs 0 and no `gnt`. First `gnt_0` appears 2 cycles after `reset` rises.
- Core write `addr` = 100, `wdata` = 7 alone: the next cycle shows `gnt_0`, `Adr` = 100, `WriteData` = 7, `MemWrite` = 1 for one cycle, and no `rvalid_0`.
- Loader read `addr` = 96 with memory[96] = 0x12345678: `gnt_1`, then the next cycle `rvalid_1` = 1 and `rdata` = 0x12345678.
- Both request continuously, no lock: grants alternate 0, 1, 0, 1 at 2-cycle spacing.
- Core `lock` = 1 with both requesting, `BURST_MAX` = 4: four consecutive `gnt_0`, then one `gnt_1`, then `gnt_0` resumes.
- Reset driven low during ISSUE of a core write: `MemWrite` is 0 the following cycle, `rvalid` is never asserted, and `rr` returns to 0.
